// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared core constants, instruction field positions and fetch FSM states
package cpu_pkg;

   localparam int AW_DEF = 9;
   localparam int IW_DEF = 16;

   localparam logic [15:0] NOP_INSTR = 16'h0000;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 13;
   localparam int OP_MSB  = 12;
   localparam int OP_LSB  = 11;

   typedef enum logic [1:0] {
      REQ,
      WAIT,
      HOLD
   } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory request/response handshake between fetch and imem
interface fetch_stage_if
   import cpu_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int IW = IW_DEF
);

   logic          req;
   logic [AW-1:0] addr;
   logic          ready;
   logic [IW-1:0] rdata;

   modport master (output req, output addr, input ready, input rdata);
   modport slave  (input req, input addr, output ready, output rdata);

endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// rtl/fetch_stage_ifid_reg.sv - generic pipeline register, priority reset > flush > stall > load
module ifid_reg #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         stall,
   input  logic         flush,
   input  logic [W-1:0] d,
   output logic         valid,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         q     <= '0;
      end else if (flush) begin
         valid <= 1'b0;
         q     <= '0;
      end else if (!stall && load) begin
         valid <= 1'b1;
         q     <= d;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC owner and single-outstanding instruction fetcher feeding the IF/ID register
module fetch_stage
   import cpu_pkg::*;
#(
   parameter int            AW       = AW_DEF,
   parameter int            IW       = IW_DEF,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic          clk,
   input  logic          reset,
   fetch_stage_if.master imem,
   input  logic          pc_load,
   input  logic [AW-1:0] pc_target,
   input  logic          ifid_stall,
   input  logic          ifid_flush,
   output logic          ifid_valid,
   output logic [IW-1:0] ifid_instr,
   output logic [AW-1:0] ifid_pc,
   output logic [2:0]    opcode,
   output logic [1:0]    op
);

   fetch_state_t  state;
   logic [AW-1:0] pc;
   logic          squash;
   logic [AW-1:0] hold_pc;
   logic [IW-1:0] hold_instr;

   logic          wait_take;
   logic          hold_take;
   logic [AW+IW-1:0] ifid_d;
   logic [AW+IW-1:0] ifid_q;

   assign imem.req  = (state == REQ);
   assign imem.addr = pc;

   // squash marks the outstanding request as wrong-path after a redirect
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= REQ;
         pc         <= RESET_PC;
         squash     <= 1'b0;
         hold_pc    <= '0;
         hold_instr <= IW'(NOP_INSTR);
      end else begin
         case (state)
            REQ: begin
               state <= WAIT;
               if (pc_load) begin
                  pc     <= pc_target;
                  squash <= 1'b1;
               end
            end
            WAIT: begin
               if (pc_load) begin
                  pc     <= pc_target;
                  squash <= !imem.ready;
                  if (imem.ready) state <= REQ;
               end else if (imem.ready) begin
                  if (squash) begin
                     squash <= 1'b0;
                     state  <= REQ;
                  end else begin
                     pc <= pc + 1'b1;
                     if (ifid_stall) begin
                        hold_pc    <= pc;
                        hold_instr <= imem.rdata;
                        state      <= HOLD;
                     end else begin
                        state <= REQ;
                     end
                  end
               end
            end
            HOLD: begin
               if (pc_load) begin
                  pc    <= pc_target;
                  state <= REQ;
               end else if (!ifid_stall) begin
                  state <= REQ;
               end
            end
            default: state <= REQ;
         endcase
      end
   end

   assign wait_take = (state == WAIT) && imem.ready && !squash && !pc_load;
   assign hold_take = (state == HOLD) && !pc_load;
   assign ifid_d    = (state == HOLD) ? {hold_pc, hold_instr} : {pc, imem.rdata};

   ifid_reg #(.W(AW + IW)) u_ifid (
      .clk   (clk),
      .rst   (reset),
      .load  (wait_take || hold_take),
      .stall (ifid_stall),
      .flush (pc_load || ifid_flush),
      .d     (ifid_d),
      .valid (ifid_valid),
      .q     (ifid_q)
   );

   assign {ifid_pc, ifid_instr} = ifid_q;

   assign opcode = ifid_instr[OPC_MSB:OPC_LSB];
   assign op     = ifid_instr[OP_MSB:OP_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized scoreboard bench for fetch_stage with a path-level reference model
`timescale 1ns/1ps
module tb_fetch_stage;

   localparam int            A   = 9;
   localparam int            I   = 16;
   localparam logic [A-1:0]  RPC = 9'h1FF;

   typedef struct packed {
      logic [I-1:0] instr;
      logic [A-1:0] pc;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          pc_load = 1'b0;
   logic [A-1:0]  pc_target = '0;
   logic          ifid_stall = 1'b0;
   logic          ifid_flush = 1'b0;
   logic          ifid_valid;
   logic [I-1:0]  ifid_instr;
   logic [A-1:0]  ifid_pc;
   logic [2:0]    opcode;
   logic [1:0]    op;

   fetch_stage_if #(.AW(A), .IW(I)) imem ();

   fetch_stage #(.AW(A), .IW(I), .RESET_PC(RPC)) dut (
      .clk        (clk),
      .reset      (reset),
      .imem       (imem),
      .pc_load    (pc_load),
      .pc_target  (pc_target),
      .ifid_stall (ifid_stall),
      .ifid_flush (ifid_flush),
      .ifid_valid (ifid_valid),
      .ifid_instr (ifid_instr),
      .ifid_pc    (ifid_pc),
      .opcode     (opcode),
      .op         (op)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [I-1:0] mem [512];
   exp_t         exp_q [$];

   // reference model: which path the program counter is on and what is in flight
   logic [A-1:0] exp_req;
   logic [A-1:0] o_addr;
   bit           outst = 0, killed = 0, req_now = 0;
   int           resp_cyc = 0, dcyc = 0, since_req = 0;
   bit           phase1 = 0, chk_flush = 0, chk_stall = 0;
   int           n_loads = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [A-1:0] pick_target();
      case ($urandom_range(0, 3))
         0:       return 9'h040;
         1:       return 9'h1FF;
         default: return A'($urandom);
      endcase
   endfunction

   // one cycle of memory behaviour and control stimulus, applied 2ns after the edge
   task automatic step(input int p_load, input int p_stall, input int lat_max, input bit spur, input bit rel);
      bit resp;
      @(posedge clk);
      #2;
      if (rel) reset = 1'b0;
      dcyc++;
      req_now = 0;
      resp = outst && (dcyc == resp_cyc);
      imem.ready = 1'b0;
      imem.rdata = I'($urandom);
      if (resp) begin
         imem.ready = 1'b1;
         imem.rdata = mem[o_addr];
      end else if (!outst && spur && $urandom_range(0, 3) == 0) begin
         imem.ready = 1'b1;
      end
      if (imem.req) begin
         chk("one_outstanding", 32'(outst && !resp), 0);
         chk("req_addr", 32'(imem.addr), 32'(exp_req));
         outst    = 1;
         req_now  = 1;
         o_addr   = imem.addr;
         killed   = 0;
         resp_cyc = dcyc + int'($urandom_range(1, lat_max));
         since_req = 0;
      end else begin
         since_req++;
         if (since_req == 60) chk("req_watchdog", 32'(since_req), 0);
      end
      pc_load    = ($urandom_range(0, 99) < p_load);
      pc_target  = pick_target();
      ifid_flush = pc_load && ($urandom_range(0, 1) == 1);
      ifid_stall = ($urandom_range(0, 99) < p_stall);
      if (outst && pc_load) killed = 1;
      if (resp) begin
         if (!killed) begin
            exp_q.push_back('{instr: mem[o_addr], pc: o_addr});
            exp_req = A'(o_addr + 9'd1);
         end
         outst = 0;
      end
      if (pc_load) begin
         exp_q.delete();
         exp_req = pc_target;
      end
      chk_flush = pc_load || ifid_flush;
      chk_stall = ifid_stall && !chk_flush;
   endtask

   // monitor: samples 1ns after each edge, before the driver acts on that cycle
   initial begin : monitor
      logic         pv;
      logic [I-1:0] pi;
      logic [A-1:0] pp;
      int           cyc;
      int           last_pop;
      exp_t         e;
      pv = 0; pi = '0; pp = '0; cyc = 0; last_pop = -1;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (reset) begin
            pv = 0;
            last_pop = -1;
         end else begin
            if (chk_flush) begin
               chk("flush_valid", 32'(ifid_valid), 0);
               chk("flush_instr", 32'(ifid_instr), 0);
               chk("flush_opcode", {29'd0, opcode}, 0);
               chk("flush_op", {30'd0, op}, 0);
            end else if (chk_stall) begin
               chk("stall_hold", {6'd0, ifid_valid, ifid_instr, ifid_pc}, {6'd0, pv, pi, pp});
            end else if (ifid_valid && (!pv || ifid_instr != pi || ifid_pc != pp)) begin
               chk("load_expected", 32'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("ifid_instr", 32'(ifid_instr), 32'(e.instr));
                  chk("ifid_pc", 32'(ifid_pc), 32'(e.pc));
                  chk("opcode", {29'd0, opcode}, {29'd0, e.instr[15:13]});
                  chk("op", {30'd0, op}, {30'd0, e.instr[12:11]});
                  if (phase1 && last_pop >= 0) chk("throughput", 32'(cyc - last_pop), 2);
                  last_pop = cyc;
                  n_loads++;
               end
            end
            pv = ifid_valid;
            pi = ifid_instr;
            pp = ifid_pc;
         end
      end
   end

   initial begin : driver
      bit got;
      imem.ready = 1'b0;
      imem.rdata = '0;
      for (int i = 0; i < 512; i++) mem[i] = 16'(32'hA000 + i);
      exp_req = RPC;

      repeat (3) @(posedge clk);
      #2;
      chk("rst_req", 32'(imem.req), 1);
      chk("rst_addr", 32'(imem.addr), 32'(RPC));
      chk("rst_valid", 32'(ifid_valid), 0);
      chk("rst_instr", 32'(ifid_instr), 0);
      chk("rst_pc", 32'(ifid_pc), 0);
      chk("rst_opcode", {29'd0, opcode}, 0);

      // straight-line fetch from 0x1FF across the wrap, 1-cycle memory
      phase1 = 1;
      step(0, 0, 1, 0, 1);
      repeat (12) step(0, 0, 1, 0, 0);
      phase1 = 0;

      for (int i = 0; i < 512; i++) mem[i] = I'($urandom);
      repeat (1500) step(8, 30, 3, 1, 0);

      // reset asserted mid-WAIT while memory answers
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         step(0, 0, 1, 0, 0);
         if (req_now) got = 1;
      end
      chk("reset_wait_reached", 32'(got), 1);
      resp_cyc = dcyc + 100;
      @(posedge clk);
      #2;
      dcyc++;
      reset      = 1'b1;
      imem.ready = 1'b1;
      imem.rdata = 16'hBEEF;
      pc_load    = 1'b0;
      ifid_stall = 1'b0;
      ifid_flush = 1'b0;
      chk_flush  = 0;
      chk_stall  = 0;
      #1;
      chk("midwait_rst_valid", 32'(ifid_valid), 0);
      chk("midwait_rst_addr", 32'(imem.addr), 32'(RPC));
      chk("midwait_rst_req", 32'(imem.req), 1);
      exp_q.delete();
      outst   = 0;
      exp_req = RPC;
      repeat (2) begin
         @(posedge clk);
         #2;
         dcyc++;
      end
      step(0, 0, 1, 0, 1);

      repeat (1500) step(8, 30, 3, 1, 0);
      repeat (20) step(0, 0, 1, 0, 0);

      @(posedge clk);
      #3;
      chk("queue_drained", 32'(exp_q.size()), 0);
      chk("loads_seen", 32'(n_loads > 200), 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
